regfile_write_arbiter: RTL

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter_pkg.sv | 19 +
 rtl/regfile_write_arbiter_rr_pick.sv | 29 ++
 rtl/regfile_write_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared defaults and FSM encoding for the register-file write arbiter.
package regfile_write_arbiter_pkg;

  localparam int unsigned NUM_REQ_DEF  = 4;
  localparam int unsigned NUM_REGS_DEF = 16;
  localparam int unsigned DATA_W_DEF   = 64;

  function automatic int unsigned addr_w(input int unsigned num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

  localparam int unsigned ADDR_W_DEF = addr_w(NUM_REGS_DEF);

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } arb_state_e;

endpackage

// File: rtl/regfile_write_arbiter_rr_pick.sv
// Round-robin select: first eligible requester after the last winner.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_eligible,
  input  logic [IDX_W-1:0]   i_last,
  output logic [NUM_REQ-1:0] o_win,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  always_comb begin : pick
    int unsigned idx;
    idx     = 0;
    o_win   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(i_last) + k) % NUM_REQ;
      if (!o_valid && i_eligible[idx]) begin
        o_win[idx] = 1'b1;
        o_idx      = IDX_W'(idx);
        o_valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates write requesters onto a shared register-file write port,
// with a one-cycle global clear sequenced through a two-state FSM.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ  = NUM_REQ_DEF,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = addr_w(NUM_REGS)
) (
  input  logic                       Clock,
  input  logic                       Clear_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic                       clr_all,
  output logic [NUM_REQ-1:0]         grant,
  output logic [DATA_W-1:0]          reg_D,
  output logic [NUM_REGS-1:0]        reg_Write,
  output logic [NUM_REGS-1:0]        reg_Clear,
  output logic                       busy,
  output logic [15:0]                contention_cnt
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e          r_state, w_state_nxt;
  logic [NUM_REQ-1:0]  r_grant, w_eligible, w_win;
  logic [IDX_W-1:0]    r_last, w_win_idx;
  logic                w_win_valid, w_issue, w_contend;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_data, r_reg_D;
  logic [NUM_REGS-1:0] r_reg_Write, w_write_dec;
  logic                r_busy;
  logic [15:0]         r_contention_cnt;

  // A requester granted this cycle is still holding req; mask it out.
  assign w_eligible = req & ~r_grant;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .i_eligible (w_eligible),
    .i_last     (r_last),
    .o_win      (w_win),
    .o_idx      (w_win_idx),
    .o_valid    (w_win_valid)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_contend   = 1'b0;
    w_write_dec = '0;
    w_addr      = req_addr[w_win_idx*ADDR_W +: ADDR_W];
    w_data      = req_data[w_win_idx*DATA_W +: DATA_W];
    case (r_state)
      ARB: begin
        w_contend = (w_eligible & (w_eligible - NUM_REQ'(1))) != '0;
        if (clr_all) w_state_nxt = CLEAR;
        else         w_issue     = w_win_valid;
      end
      CLEAR:   w_state_nxt = ARB;
      default: w_state_nxt = ARB;
    endcase
    // Register 0 reads as zero and out-of-range targets are dropped, but both still get a grant.
    if (w_issue && (w_addr != '0) && (32'(w_addr) < NUM_REGS))
      w_write_dec[w_addr] = 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (!Clear_n) begin
      r_state          <= ARB;
      r_grant          <= '0;
      r_reg_Write      <= '0;
      r_reg_D          <= '0;
      r_busy           <= 1'b0;
      r_contention_cnt <= '0;
      r_last           <= IDX_W'(NUM_REQ - 1);
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_issue ? w_win : '0;
      r_reg_Write <= w_write_dec;
      r_busy      <= (|req) | (w_state_nxt == CLEAR);
      if (w_issue) begin
        r_reg_D <= w_data;
        r_last  <= w_win_idx;
      end
      if (w_contend && (r_contention_cnt != '1))
        r_contention_cnt <= r_contention_cnt + 16'd1;
    end
  end

  assign grant          = r_grant;
  assign reg_D          = r_reg_D;
  assign reg_Write      = r_reg_Write;
  assign reg_Clear      = {NUM_REGS{r_state == CLEAR}};
  assign busy           = r_busy;
  assign contention_cnt = r_contention_cnt;

endmodule
